sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Upstream control stage for the gated SR latch.
- Takes asynchronous set/clear request inputs and synchronizes them, debounces them, and edge-detects them.
- Arbitrates the requests and produces clean, mutually exclusive S/R/En pulses for the latch.
- Reads the latch Q back and flags any disagreement with the expected state.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles needed before a debounced level changes (>=1).
- PULSE_CYCLES, 2: width of each S/R/En pulse in clk cycles (>=1).
- GAP_CYCLES, 1: minimum idle cycles after SETTLE before the next pulse (0 allowed; 0 skips GAP).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_req  in  1  asynchronous set request (push-button level).
- clr_req  in  1  asynchronous clear request (push-button level).
- q_fb  in  1  latch Q readback, asynchronous.
- clr_mismatch  in  1  synchronous clear of the mismatch flag.
- S  out  1  latch set input, registered.
- R  out  1  latch reset input, registered.
- En  out  1  latch enable, registered.
- busy  out  1  high while a pulse/settle/gap sequence is in progress.
- state_exp  out  1  expected latch state.
- mismatch  out  1  sticky error flag: readback differed from state_exp.

Behaviour:
- Clocking and reset:
  - One clock domain (clk) with asynchronous active-low reset rst_n.
  - While rst_n=0: all flops clear. S=R=En=0, busy=0, state_exp=0, mismatch=0, pending flags=0, debounced levels=0, sync flops=0, FSM=IDLE.
  - Reset asserted mid-pulse drops S/R/En immediately (asynchronously). Pending requests are discarded.
- Input conditioning:
  - set_req, clr_req and q_fb each pass through a 2-flop synchronizer.
  - Each request has its own debouncer. A counter increments while the synchronized level differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A debounced 0->1 transition sets that request's pending flag. Falling transitions are ignored.
  - A repeat rising edge while the flag is already pending merges: at most one pulse per pending flag.
- Latency (defaults): input rises before edge 0 -> debounced level and pending set at edge 2+DEBOUNCE_CYCLES -> S/R/En high from edge 3+DEBOUNCE_CYCLES (edge 7).
- FSM states: IDLE, PULSE_SET, PULSE_CLR, SETTLE, GAP.
  - IDLE:
    - If clr pending -> PULSE_CLR: clear that pending flag, R=En=1, state_exp<=0.
    - Else if set pending -> PULSE_SET: clear that pending flag, S=En=1, state_exp<=1.
    - Clear has priority when both are pending. Set stays pending and is serviced on the next IDLE visit.
  - PULSE_SET / PULSE_CLR:
    - Last exactly PULSE_CYCLES cycles, then go to SETTLE with S=R=En=0.
    - Requests that arrive here are only recorded as pending.
  - SETTLE:
    - Lasts exactly 3 cycles, covering the synchronizer delay.
    - On its last cycle, compare synchronized q_fb with state_exp. If they differ, mismatch<=1.
    - Then go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: lasts GAP_CYCLES cycles, then goes to IDLE.
  - A request serviced from IDLE starts its pulse on the edge leaving IDLE. Back-to-back requests are therefore separated by at least 3+GAP_CYCLES+1 low cycles.
- Output invariants:
  - S and R are never both 1.
  - En = S|R at all times.
  - busy=1 in every state except IDLE.
- Repeated requests: a set request while state_exp=1, or a clear request while state_exp=0, still produces a full pulse.
- mismatch:
  - Sticky; cleared only by clr_mismatch=1 or reset.
  - If clr_mismatch and a new compare failure occur in the same cycle, the set wins.

Test Plan:
- Clean set, defaults: set_req=1 held 12 cycles, q_fb driven by a real SR latch model -> S=En=1 on edges 7-8, R=0, state_exp=1 from edge 7, busy high edges 7-12, mismatch stays 0.
- Glitch rejection: set_req pulsed high for 3 cycles, then low -> no pulse on S/R/En, pending never set, busy stays 0.
- Simultaneous requests: set_req and clr_req both rise at the same edge -> R pulse first (edges 7-8), then S pulse starting edge 14; S&R never both 1; final state_exp=1.
- Feedback fault: q_fb tied 0, then a set request -> mismatch=1 on the last SETTLE cycle and held; clr_mismatch=1 for one cycle -> mismatch=0.
- Reset mid-pulse: rst_n driven 0 during PULSE_SET cycle 1 -> S and En fall without waiting for clk; after release all outputs read 0 and no pulse is replayed.
- Merge during busy: two debounced set edges arrive during PULSE_CLR -> exactly one S pulse follows the gap.

Source files
------------

// File: rtl/sr_latch_driver_if.sv
// ============================================================================
//  Module   : sr_latch_driver_if
//  Purpose  : Request, readback and latch-drive signals of sr_latch_driver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_latch_driver_if;
  logic set_req;
  logic clr_req;
  logic q_fb;
  logic clr_mismatch;
  logic S;
  logic R;
  logic En;
  logic busy;
  logic state_exp;
  logic mismatch;

  modport master (
    input  set_req, clr_req, q_fb, clr_mismatch,
    output S, R, En, busy, state_exp, mismatch
  );

  modport slave (
    output set_req, clr_req, q_fb, clr_mismatch,
    input  S, R, En, busy, state_exp, mismatch
  );
endinterface

`default_nettype wire

// File: rtl/sr_latch_driver.sv
// ============================================================================
//  Module   : sr_latch_driver
//  Purpose  : Conditions set/clear requests and drives exclusive S/R/En pulses
//             into a gated SR latch, checking the latch readback afterwards.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sr_latch_driver_if.master bus
);

  localparam int c_DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_SEQ_MAX = (PULSE_CYCLES > 3)
                           ? ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES)
                           : ((GAP_CYCLES > 3) ? GAP_CYCLES : 3);
  localparam int c_SEQ_W   = $clog2(c_SEQ_MAX);

  localparam logic [c_DEB_W-1:0] c_DEB_DONE    = c_DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [c_SEQ_W-1:0] c_PULSE_LAST  = c_SEQ_W'(PULSE_CYCLES - 1);
  localparam logic [c_SEQ_W-1:0] c_SETTLE_LAST = c_SEQ_W'(2);
  localparam logic [c_SEQ_W-1:0] c_GAP_LAST    = c_SEQ_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PULSE_SET = 3'd1,
    ST_PULSE_CLR = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // Bit 0 = set request, bit 1 = clear request, bit 2 = latch readback.
  logic [2:0] w_async;
  logic [2:0] r_meta;
  logic [2:0] r_sync;

  assign w_async = {bus.q_fb, bus.clr_req, bus.set_req};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_async;
      r_sync <= r_meta;
    end
  end

  logic [1:0] w_rise;

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync[gi] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DEB_DONE) begin
        r_lvl <= r_sync[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_rise[gi] = r_sync[gi] & ~r_lvl & (r_cnt == c_DEB_DONE);
  end

  state_t             r_state, w_state_nxt;
  logic [c_SEQ_W-1:0] r_seq, w_seq_nxt;
  logic [1:0]         r_pend, w_pend_nxt;
  logic               r_s, r_r, r_en, r_exp, r_mis;
  logic               w_s_nxt, w_r_nxt, w_en_nxt, w_exp_nxt, w_mis_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_pend  <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_en    <= 1'b0;
      r_exp   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_seq   <= w_seq_nxt;
      r_pend  <= w_pend_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_en    <= w_en_nxt;
      r_exp   <= w_exp_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq + 1'b1;
    w_pend_nxt  = r_pend | w_rise;
    w_s_nxt     = r_s;
    w_r_nxt     = r_r;
    w_en_nxt    = r_en;
    w_exp_nxt   = r_exp;
    w_mis_nxt   = r_mis & ~bus.clr_mismatch;

    case (r_state)
      ST_IDLE: begin
        w_seq_nxt = '0;
        // Clear wins a tie; the set request stays pending for the next visit.
        if (r_pend[1]) begin
          w_state_nxt   = ST_PULSE_CLR;
          w_pend_nxt[1] = w_rise[1];
          w_r_nxt       = 1'b1;
          w_en_nxt      = 1'b1;
          w_exp_nxt     = 1'b0;
        end else if (r_pend[0]) begin
          w_state_nxt   = ST_PULSE_SET;
          w_pend_nxt[0] = w_rise[0];
          w_s_nxt       = 1'b1;
          w_en_nxt      = 1'b1;
          w_exp_nxt     = 1'b1;
        end
      end
      ST_PULSE_SET, ST_PULSE_CLR: begin
        if (r_seq == c_PULSE_LAST) begin
          w_state_nxt = ST_SETTLE;
          w_seq_nxt   = '0;
          w_s_nxt     = 1'b0;
          w_r_nxt     = 1'b0;
          w_en_nxt    = 1'b0;
        end
      end
      ST_SETTLE: begin
        // Three cycles let the latch output propagate through the synchronizer.
        if (r_seq == c_SETTLE_LAST) begin
          w_seq_nxt   = '0;
          w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          if (r_sync[2] != r_exp) begin
            w_mis_nxt = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_seq == c_GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_seq_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_seq_nxt   = '0;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.S         = r_s;
  assign bus.R         = r_r;
  assign bus.En        = r_en;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.state_exp = r_exp;
  assign bus.mismatch  = r_mis;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
// ============================================================================
//  Module   : tb_sr_latch_driver
//  Purpose  : Directed-vector bench for sr_latch_driver with SR latch models.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic q_fault = 1'b0;
  logic latch_q, latch_q2;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sr_latch_driver_if bus ();
  sr_latch_driver_if bus2 ();

  sr_latch_driver u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  sr_latch_driver #(
    .DEBOUNCE_CYCLES (1),
    .PULSE_CYCLES    (8),
    .GAP_CYCLES      (0)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.master)
  );

  // Gated SR latch seen at clock granularity; reset mirrors a power-on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q  <= 1'b0;
      latch_q2 <= 1'b0;
    end else begin
      if (bus.En && bus.S)       latch_q <= 1'b1;
      else if (bus.En && bus.R)  latch_q <= 1'b0;
      if (bus2.En && bus2.S)      latch_q2 <= 1'b1;
      else if (bus2.En && bus2.R) latch_q2 <= 1'b0;
    end
  end

  assign bus.q_fb  = q_fault ? 1'b0 : latch_q;
  assign bus2.q_fb = latch_q2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {S, R, En, busy, state_exp, mismatch}
  function automatic logic [5:0] obs1();
    return {bus.S, bus.R, bus.En, bus.busy, bus.state_exp, bus.mismatch};
  endfunction

  function automatic logic [5:0] obs2();
    return {bus2.S, bus2.R, bus2.En, bus2.busy, bus2.state_exp, bus2.mismatch};
  endfunction

  function automatic logic [5:0] pack(input logic s, input logic r, input logic busy,
                                      input logic st, input logic mis);
    return {s, r, s | r, busy, st, mis};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  logic s_e, r_e, b_e, st_e;

  initial begin
    bus.set_req       = 1'b0;
    bus.clr_req       = 1'b0;
    bus.clr_mismatch  = 1'b0;
    bus2.set_req      = 1'b0;
    bus2.clr_req      = 1'b0;
    bus2.clr_mismatch = 1'b0;

    idle(3);
    check("reset_dut", 32'(obs1()), 32'h0);
    check("reset_dut2", 32'(obs2()), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);

    // Clean set: request level held for 12 edges.
    @(posedge clk); #1 bus.set_req = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); @(negedge clk);
      s_e = (k == 7 || k == 8);
      check($sformatf("set k=%0d", k), 32'(obs1()),
            32'(pack(s_e, 1'b0, (k >= 7 && k <= 12), (k >= 7), 1'b0)));
      if (k == 11) bus.set_req = 1'b0;
    end
    idle(12);

    // Three-cycle glitch must be filtered out completely.
    @(posedge clk); #1 bus.set_req = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("glitch k=%0d", k), 32'(obs1()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
      if (k == 2) bus.set_req = 1'b0;
    end
    idle(6);

    // Simultaneous set/clear: clear first, then set after settle+gap.
    @(posedge clk); #1 begin bus.set_req = 1'b1; bus.clr_req = 1'b1; end
    for (int k = 0; k <= 21; k++) begin
      @(posedge clk); @(negedge clk);
      s_e  = (k == 14 || k == 15);
      r_e  = (k == 7 || k == 8);
      b_e  = (k >= 7 && k <= 12) || (k >= 14 && k <= 19);
      st_e = (k >= 14) ? 1'b1 : ((k >= 7) ? 1'b0 : 1'b1);
      check($sformatf("both k=%0d", k), 32'(obs1()), 32'(pack(s_e, r_e, b_e, st_e, 1'b0)));
      if (k == 12) begin bus.set_req = 1'b0; bus.clr_req = 1'b0; end
    end
    idle(12);

    // Feedback stuck low: mismatch raised at end of settle and held.
    q_fault = 1'b1;
    @(posedge clk); #1 bus.set_req = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      s_e = (k == 7 || k == 8);
      check($sformatf("fault k=%0d", k), 32'(obs1()),
            32'(pack(s_e, 1'b0, (k >= 7 && k <= 12), 1'b1, (k >= 12))));
      if (k == 11) bus.set_req = 1'b0;
    end
    bus.clr_mismatch = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.clr_mismatch = 1'b0;
    check("mismatch_cleared", 32'(bus.mismatch), 32'h0);
    q_fault = 1'b0;
    idle(12);
    check("mismatch_stays_clear", 32'(obs1()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));

    // Reset during the first pulse cycle drops the outputs without a clock edge.
    @(posedge clk); #1 bus.set_req = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("pre_rst k=%0d", k), 32'(obs1()),
            32'(pack(k == 7, 1'b0, k == 7, 1'b1, 1'b0)));
    end
    bus.set_req = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("rst_async", 32'({bus.S, bus.R, bus.En}), 32'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("post_rst k=%0d", k), 32'(obs1()), 32'h0);
    end

    // Second instance (debounce 1, pulse 8, no gap): two set edges during the
    // clear pulse merge into a single set pulse.
    @(posedge clk); #1 bus2.clr_req = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      s_e  = (k >= 16 && k <= 23);
      r_e  = (k >= 4 && k <= 11);
      b_e  = (k >= 4 && k <= 14) || (k >= 16 && k <= 26);
      st_e = (k >= 16);
      check($sformatf("merge k=%0d", k), 32'(obs2()), 32'(pack(s_e, r_e, b_e, st_e, 1'b0)));
      if (k == 1 || k == 6) bus2.set_req = 1'b1;
      if (k == 4)           bus2.set_req = 1'b0;
      if (k == 12) begin bus2.set_req = 1'b0; bus2.clr_req = 1'b0; end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
